// File: rtl/io_pkg.sv
// io_pkg: register addresses, ctrl bit layout and ctrl-register helpers for the MMIO controller
package io_pkg;
  localparam logic [31:0] A_HEX   = 32'hF000_0000;
  localparam logic [31:0] A_LEDR  = 32'hF000_0004;
  localparam logic [31:0] A_LEDG  = 32'hF000_0008;
  localparam logic [31:0] A_KDATA = 32'hF000_0010;
  localparam logic [31:0] A_SDATA = 32'hF000_0014;
  localparam logic [31:0] A_TCNT  = 32'hF000_0020;
  localparam logic [31:0] A_TLIM  = 32'hF000_0024;
  localparam logic [31:0] A_KCTRL = 32'hF000_0110;
  localparam logic [31:0] A_SCTRL = 32'hF000_0114;
  localparam logic [31:0] A_TCTRL = 32'hF000_0120;
  localparam int CTRL_READY   = 0;
  localparam int CTRL_OVERRUN = 2;
  localparam int CTRL_IE      = 8;
  typedef struct packed {
    logic ie;
    logic ovr;
    logic rdy;
  } ctrl_t;
  // An event beats a same-cycle read clear; overrun only sets when ready would have stayed set.
  function automatic ctrl_t ctrl_next(ctrl_t c, logic ev, logic clr, logic wr, logic [31:0] wd);
    ctrl_t n;
    n.rdy = ev | (c.rdy & ~clr);
    n.ovr = (ev & c.rdy & ~clr) | (c.ovr & ~(wr & ~wd[CTRL_OVERRUN]));
    n.ie  = wr ? wd[CTRL_IE] : c.ie;
    return n;
  endfunction
  function automatic logic [31:0] ctrl_word(ctrl_t c);
    logic [31:0] r;
    r = '0;
    r[CTRL_READY]   = c.rdy;
    r[CTRL_OVERRUN] = c.ovr;
    r[CTRL_IE]      = c.ie;
    return r;
  endfunction
endpackage

// File: rtl/io_sync_debounce.sv
// io_sync_debounce: two-flop synchroniser plus stability filter; commits a value once it has held STABLE_CYCLES clks
module io_sync_debounce #(
  parameter int WIDTH = 4,
  parameter int STABLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] value,
  output logic             change
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  logic [WIDTH-1:0] s1, s2, last;
  logic [CW-1:0] cnt;
  logic [CW:0] run;
  // run is how many consecutive clks the synchronised value has held, counting this one
  always_comb run = (s2 == last) ? {1'b0, cnt} + 1'b1 : (CW+1)'(1);
  assign change = (s2 != value) && (run >= (CW+1)'(STABLE_CYCLES));
  // synchronise, track the run length (saturating) and commit on a qualified change
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      last <= '0;
      cnt <= '0;
      value <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
      last <= s2;
      cnt <= (run > (CW+1)'(STABLE_CYCLES)) ? CW'(STABLE_CYCLES) : run[CW-1:0];
      if (change) value <= s2;
    end
endmodule

// File: rtl/mmio_io_controller.sv
// mmio_io_controller: memory-mapped HEX/LED outputs, debounced key/switch inputs and a programmable timer
module mmio_io_controller
  import io_pkg::*;
#(
  parameter int DBITS = 32,
  parameter int KEY_BITS = 4,
  parameter int SW_BITS = 10,
  parameter int LEDR_BITS = 10,
  parameter int LEDG_BITS = 8,
  parameter int HEX_BITS = 16,
  parameter int SW_DEBOUNCE_CYCLES = 100000,
  parameter int TIMER_TICK_CYCLES = 100000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DBITS-1:0]     addr,
  input  logic                 we,
  input  logic                 re,
  input  logic [DBITS-1:0]     wdata,
  output logic [DBITS-1:0]     rdata,
  input  logic [KEY_BITS-1:0]  key_in,
  input  logic [SW_BITS-1:0]   sw_in,
  output logic [HEX_BITS-1:0]  hex_out,
  output logic [LEDR_BITS-1:0] ledr_out,
  output logic [LEDG_BITS-1:0] ledg_out,
  output logic                 intr
);
  localparam int PW = TIMER_TICK_CYCLES > 1 ? $clog2(TIMER_TICK_CYCLES) : 1;
  logic [DBITS-3:0] w;
  logic [KEY_BITS-1:0] kdata;
  logic [SW_BITS-1:0] sdata;
  logic k_chg, s_chg;
  ctrl_t kc, sc, tc;
  logic [DBITS-1:0] tcnt, tlim;
  logic [PW-1:0] presc;
  logic tick, wrap, t_ev, wr_tcnt, wr_tlim;
  assign w = addr[DBITS-1:2];
  assign wr_tcnt = we && w == A_TCNT[DBITS-1:2];
  assign wr_tlim = we && w == A_TLIM[DBITS-1:2];
  assign tick = presc == PW'(TIMER_TICK_CYCLES - 1);
  assign wrap = tlim != '0 && tcnt == tlim - 1'b1;
  assign t_ev = tick && wrap && !wr_tcnt && !wr_tlim;
  assign intr = (kc.rdy & kc.ie) | (sc.rdy & sc.ie) | (tc.rdy & tc.ie);
  io_sync_debounce #(.WIDTH(KEY_BITS), .STABLE_CYCLES(1)) u_key (
    .clk(clk), .reset(reset), .din(~key_in), .value(kdata), .change(k_chg)
  );
  io_sync_debounce #(.WIDTH(SW_BITS), .STABLE_CYCLES(SW_DEBOUNCE_CYCLES)) u_sw (
    .clk(clk), .reset(reset), .din(sw_in), .value(sdata), .change(s_chg)
  );
  // combinational read mux; anything unmapped reads as zero
  always_comb
    case (w)
      A_HEX[DBITS-1:2]:   rdata = DBITS'(hex_out);
      A_LEDR[DBITS-1:2]:  rdata = DBITS'(ledr_out);
      A_LEDG[DBITS-1:2]:  rdata = DBITS'(ledg_out);
      A_KDATA[DBITS-1:2]: rdata = DBITS'(kdata);
      A_SDATA[DBITS-1:2]: rdata = DBITS'(sdata);
      A_TCNT[DBITS-1:2]:  rdata = tcnt;
      A_TLIM[DBITS-1:2]:  rdata = tlim;
      A_KCTRL[DBITS-1:2]: rdata = DBITS'(ctrl_word(kc));
      A_SCTRL[DBITS-1:2]: rdata = DBITS'(ctrl_word(sc));
      A_TCTRL[DBITS-1:2]: rdata = DBITS'(ctrl_word(tc));
      default:            rdata = '0;
    endcase
  // CPU-writable display and LED registers
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      hex_out <= '0;
      ledr_out <= '0;
      ledg_out <= '0;
    end else begin
      if (we && w == A_HEX[DBITS-1:2]) hex_out <= wdata[HEX_BITS-1:0];
      if (we && w == A_LEDR[DBITS-1:2]) ledr_out <= wdata[LEDR_BITS-1:0];
      if (we && w == A_LEDG[DBITS-1:2]) ledg_out <= wdata[LEDG_BITS-1:0];
    end
  // per-device status/control: events set ready, data reads clear it, ctrl writes touch IE and overrun
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      kc <= '0;
      sc <= '0;
      tc <= '0;
    end else begin
      kc <= ctrl_next(kc, k_chg, re && w == A_KDATA[DBITS-1:2], we && w == A_KCTRL[DBITS-1:2], wdata);
      sc <= ctrl_next(sc, s_chg, re && w == A_SDATA[DBITS-1:2], we && w == A_SCTRL[DBITS-1:2], wdata);
      tc <= ctrl_next(tc, t_ev, re && w == A_TCNT[DBITS-1:2], we && w == A_TCTRL[DBITS-1:2], wdata);
    end
  // prescaler and timer counter; CPU writes take priority over a same-cycle tick
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      tcnt <= '0;
      tlim <= '0;
      presc <= '0;
    end else if (wr_tlim) begin
      tlim <= wdata;
      tcnt <= '0;
      presc <= '0;
    end else if (wr_tcnt) begin
      tcnt <= wdata;
      presc <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) tcnt <= wrap ? '0 : tcnt + 1'b1;
    end
endmodule

// File: tb/tb_mmio_io_controller.sv
// tb_mmio_io_controller: reference-model bench with per-cycle output comparison plus directed literal checks
module tb_mmio_io_controller;
  localparam int SWD = 4;
  localparam int TT = 3;
  localparam logic [31:0] HEX = 32'hF000_0000, LEDR = 32'hF000_0004, LEDG = 32'hF000_0008;
  localparam logic [31:0] KDATA = 32'hF000_0010, SDATA = 32'hF000_0014, TCNT = 32'hF000_0020;
  localparam logic [31:0] TLIM = 32'hF000_0024, KCTRL = 32'hF000_0110, SCTRL = 32'hF000_0114;
  localparam logic [31:0] TCTRL = 32'hF000_0120;

  logic clk = 0, reset = 1, we = 0, re = 0;
  logic [31:0] addr = 0, wdata = 0, rdata;
  logic [3:0] key_in = 4'hF;
  logic [9:0] sw_in = 0;
  logic [15:0] hex_out;
  logic [9:0] ledr_out;
  logic [7:0] ledg_out;
  logic intr;
  int n_tests = 0, n_fail = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  mmio_io_controller #(.SW_DEBOUNCE_CYCLES(SWD), .TIMER_TICK_CYCLES(TT)) dut (
    .clk(clk), .reset(reset), .addr(addr), .we(we), .re(re), .wdata(wdata), .rdata(rdata),
    .key_in(key_in), .sw_in(sw_in), .hex_out(hex_out), .ledr_out(ledr_out),
    .ledg_out(ledg_out), .intr(intr)
  );

  // reference model state: device 0 = keys, 1 = switches, 2 = timer
  logic [15:0] m_hex;
  logic [9:0] m_ledr, m_sdata;
  logic [7:0] m_ledg;
  logic [3:0] m_kdata, ks;
  logic [31:0] m_tcnt, m_tlim, ma;
  int m_phase, n;
  bit m_rdy[3], m_ovr[3], m_ie[3];
  bit kev, sev, tev, tick, tw, stable;
  logic [3:0] kq[$];
  logic [9:0] sq[$];

  function automatic logic [31:0] ctrl_val(int d);
    return {23'b0, m_ie[d], 5'b0, m_ovr[d], 1'b0, m_rdy[d]};
  endfunction

  function automatic logic [31:0] m_read(logic [31:0] a);
    case ({a[31:2], 2'b00})
      HEX:     return {16'b0, m_hex};
      LEDR:    return {22'b0, m_ledr};
      LEDG:    return {24'b0, m_ledg};
      KDATA:   return {28'b0, m_kdata};
      SDATA:   return {22'b0, m_sdata};
      TCNT:    return m_tcnt;
      TLIM:    return m_tlim;
      KCTRL:   return ctrl_val(0);
      SCTRL:   return ctrl_val(1);
      TCTRL:   return ctrl_val(2);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_intr();
    return (m_rdy[0] & m_ie[0]) | (m_rdy[1] & m_ie[1]) | (m_rdy[2] & m_ie[2]);
  endfunction

  task automatic upd(int d, bit ev, bit clr, bit wr);
    if (ev && m_rdy[d] && !clr) m_ovr[d] = 1;
    else if (wr && !wdata[2]) m_ovr[d] = 0;
    if (ev) m_rdy[d] = 1;
    else if (clr) m_rdy[d] = 0;
    if (wr) m_ie[d] = wdata[8];
  endtask

  // The model keeps a short history of raw input samples: the value seen by the
  // logic at edge k is the sample taken two edges earlier.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hex = 0; m_ledr = 0; m_ledg = 0; m_kdata = 0; m_sdata = 0;
      m_tcnt = 0; m_tlim = 0; m_phase = 0;
      for (int i = 0; i < 3; i++) begin m_rdy[i] = 0; m_ovr[i] = 0; m_ie[i] = 0; end
      kq = {}; sq = {};
      repeat (6) begin kq.push_back(4'h0); sq.push_back(10'h0); end
    end else begin
      ma = {addr[31:2], 2'b00};
      kq.push_back(~key_in);
      sq.push_back(sw_in);
      while (kq.size() > 6) void'(kq.pop_front());
      while (sq.size() > 6) void'(sq.pop_front());
      n = sq.size();
      ks = kq[n-3];
      kev = ks != m_kdata;
      stable = sq[n-3] == sq[n-4] && sq[n-3] == sq[n-5] && sq[n-3] == sq[n-6];
      sev = stable && sq[n-3] != m_sdata;
      tw = we && (ma == TCNT || ma == TLIM);
      tick = m_phase == TT - 1;
      tev = tick && !tw && m_tlim != 0 && m_tcnt == m_tlim - 1;
      upd(0, kev, re && ma == KDATA, we && ma == KCTRL);
      upd(1, sev, re && ma == SDATA, we && ma == SCTRL);
      upd(2, tev, re && ma == TCNT, we && ma == TCTRL);
      if (kev) m_kdata = ks;
      if (sev) m_sdata = sq[n-3];
      if (we && ma == TLIM) begin
        m_tlim = wdata; m_tcnt = 0; m_phase = 0;
      end else if (we && ma == TCNT) begin
        m_tcnt = wdata; m_phase = 0;
      end else begin
        if (tick) m_tcnt = (m_tlim != 0 && m_tcnt == m_tlim - 1) ? 32'h0 : m_tcnt + 1;
        m_phase = (m_phase + 1) % TT;
      end
      if (we && ma == HEX) m_hex = wdata[15:0];
      if (we && ma == LEDR) m_ledr = wdata[9:0];
      if (we && ma == LEDG) m_ledg = wdata[7:0];
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // per-cycle comparison against the model, away from the active edge
  always @(negedge clk)
    if (chk_en) begin
      chk("hex_out", {16'b0, hex_out}, {16'b0, m_hex});
      chk("ledr_out", {22'b0, ledr_out}, {22'b0, m_ledr});
      chk("ledg_out", {24'b0, ledg_out}, {24'b0, m_ledg});
      chk("intr", {31'b0, intr}, {31'b0, m_intr()});
      chk("rdata", rdata, m_read(addr));
    end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(logic [31:0] a, logic [31:0] d);
    addr = a; wdata = d; we = 1;
    step();
    we = 0;
  endtask

  task automatic peek(string nm, logic [31:0] a, logic [31:0] exp);
    addr = a; re = 0;
    #1;
    chk(nm, rdata, exp);
  endtask

  task automatic rdclr(logic [31:0] a);
    addr = a; re = 1;
    step();
    re = 0;
  endtask

  initial begin
    repeat (2) step();
    reset = 0;
    chk_en = 1;
    step();
    // mid-run reset
    wr(LEDR, 32'h3FF);
    wr(TCNT, 32'h7);
    chk("ledr_before_reset", {22'b0, ledr_out}, 32'h3FF);
    peek("tcnt_before_reset", TCNT, 32'h7);
    reset = 1;
    #1;
    chk("ledr_after_reset", {22'b0, ledr_out}, 32'h0);
    chk("hex_after_reset", {16'b0, hex_out}, 32'h0);
    chk("intr_after_reset", {31'b0, intr}, 32'h0);
    peek("tcnt_after_reset", TCNT, 32'h0);
    step();
    reset = 0;
    step();
    // output registers and masking
    wr(HEX, 32'h1234);
    wr(LEDG, 32'hFFFF_FFFF);
    chk("hex_out_1234", {16'b0, hex_out}, 32'h1234);
    chk("ledg_out_ff", {24'b0, ledg_out}, 32'hFF);
    peek("ledg_read", LEDG, 32'h0000_00FF);
    wr(HEX, 32'hFFFF_FFFF);
    peek("hex_upper_zero", HEX, 32'h0000_FFFF);
    wr(32'hF000_0030, 32'hDEAD);
    peek("unmapped_read", 32'hF000_0030, 32'h0);
    // key path: 3-clk latency, overrun, IE, read clear
    key_in = 4'b1110;
    step(); step();
    peek("kdata_at_2clk", KDATA, 32'h0);
    step();
    peek("kdata_at_3clk", KDATA, 32'h1);
    peek("kctrl_ready", KCTRL, 32'h1);
    key_in = 4'b1111;
    repeat (3) step();
    peek("kctrl_overrun", KCTRL, 32'h5);
    peek("kdata_released", KDATA, 32'h0);
    wr(KCTRL, 32'h100);
    peek("kctrl_ie", KCTRL, 32'h101);
    chk("intr_key", {31'b0, intr}, 32'h1);
    rdclr(KDATA);
    peek("kctrl_cleared", KCTRL, 32'h100);
    chk("intr_key_cleared", {31'b0, intr}, 32'h0);
    wr(KCTRL, 32'h105);
    peek("kctrl_ro_bits", KCTRL, 32'h100);
    // switch debounce with a 2-clk glitch
    sw_in = 10'h2A0;
    step(); step();
    sw_in = 10'h2A1;
    step(); step();
    sw_in = 10'h2A0;
    repeat (5) step();
    peek("sdata_not_yet", SDATA, 32'h0);
    step();
    peek("sdata_committed", SDATA, 32'h2A0);
    peek("sctrl_ready", SCTRL, 32'h1);
    // timer with limit 3
    wr(TLIM, 32'h3);
    peek("tcnt_after_tlim", TCNT, 32'h0);
    wr(TCTRL, 32'h100);
    step(); step();
    peek("tcnt_1", TCNT, 32'h1);
    repeat (3) step();
    peek("tcnt_2", TCNT, 32'h2);
    step(); step();
    peek("tctrl_before_wrap", TCTRL, 32'h100);
    step();
    peek("tcnt_wrap", TCNT, 32'h0);
    peek("tctrl_wrap", TCTRL, 32'h101);
    chk("intr_timer", {31'b0, intr}, 32'h1);
    repeat (9) step();
    peek("tctrl_overrun", TCTRL, 32'h105);
    wr(TCTRL, 32'h0);
    rdclr(TCNT);
    // same-cycle key event and KDATA read: event wins
    key_in = 4'b1110;
    step(); step();
    addr = KDATA; re = 1;
    step();
    re = 0;
    peek("kctrl_event_wins", KCTRL, 32'h101);
    peek("kdata_event_wins", KDATA, 32'h1);
    // free-running timer wraps modulo 2^32 without setting ready
    wr(TLIM, 32'h0);
    wr(TCNT, 32'hFFFF_FFFF);
    step(); step();
    peek("tcnt_max", TCNT, 32'hFFFF_FFFF);
    step();
    peek("tcnt_mod_wrap", TCNT, 32'h0);
    peek("tctrl_free_run", TCTRL, 32'h0);
    step();
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
